// File: rtl/sram_arbiter.sv
// Two-port arbiter and access sequencer for the 1Mx16 async SRAM (recorder writes, player reads).
// Optional feature: define SRAM_ARB_RR_EN for round-robin arbitration; default is write-priority.
module sram_arbiter #(
    parameter int ADDR_W    = 20,
    parameter int DATA_W    = 16,
    parameter int WR_CYCLES = 2,
    parameter int RD_CYCLES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_wr_req,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_wr_ack,
    input  logic              i_rd_req,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic              o_rd_ack,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_busy,
    output logic [2:0]        o_state,
    output logic [ADDR_W-1:0] o_SRAM_ADDR,
    inout  wire  [DATA_W-1:0] io_SRAM_DQ,
    output logic              o_SRAM_CE_N,
    output logic              o_SRAM_OE_N,
    output logic              o_SRAM_WE_N,
    output logic              o_SRAM_UB_N,
    output logic              o_SRAM_LB_N
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WR      = 3'd1;
    localparam logic [2:0] WR_DONE = 3'd2;
    localparam logic [2:0] RD      = 3'd3;
    localparam logic [2:0] RD_DONE = 3'd4;

    localparam int MAX_CYC = (WR_CYCLES > RD_CYCLES) ? WR_CYCLES : RD_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    // Handshake: each req is a level held (with its address/data) until its one-cycle ack;
    // a req still high in the cycle after its ack is a fresh request.
    logic [2:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] wdata;
    logic              dq_oe;
    logic              grant_wr;
    logic              grant_rd;

`ifdef SRAM_ARB_RR_EN
    logic last_rd;

    always_comb begin
        grant_wr = i_wr_req && (!i_rd_req || last_rd);
        grant_rd = i_rd_req && !grant_wr;
    end
`else
    always_comb begin
        grant_wr = i_wr_req;
        grant_rd = i_rd_req && !grant_wr;
    end
`endif

    assign io_SRAM_DQ = dq_oe ? wdata : {DATA_W{1'bz}};
    assign o_state    = state;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            wdata       <= '0;
            dq_oe       <= 1'b0;
            o_wr_ack    <= 1'b0;
            o_rd_ack    <= 1'b0;
            o_busy      <= 1'b0;
            o_rd_data   <= '0;
            o_SRAM_ADDR <= '0;
            o_SRAM_CE_N <= 1'b1;
            o_SRAM_OE_N <= 1'b1;
            o_SRAM_WE_N <= 1'b1;
            o_SRAM_UB_N <= 1'b1;
            o_SRAM_LB_N <= 1'b1;
`ifdef SRAM_ARB_RR_EN
            last_rd     <= 1'b1;
`endif
        end else begin
            o_wr_ack <= 1'b0;
            o_rd_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_wr) begin
                        state       <= WR;
                        cnt         <= '0;
                        o_SRAM_ADDR <= i_wr_addr;
                        wdata       <= i_wr_data;
                        dq_oe       <= 1'b1;
                        o_busy      <= 1'b1;
                        o_SRAM_CE_N <= 1'b0;
                        o_SRAM_OE_N <= 1'b1;
                        o_SRAM_WE_N <= 1'b0;
                        o_SRAM_UB_N <= 1'b0;
                        o_SRAM_LB_N <= 1'b0;
`ifdef SRAM_ARB_RR_EN
                        last_rd     <= 1'b0;
`endif
                    end else if (grant_rd) begin
                        state       <= RD;
                        cnt         <= '0;
                        o_SRAM_ADDR <= i_rd_addr;
                        dq_oe       <= 1'b0;
                        o_busy      <= 1'b1;
                        o_SRAM_CE_N <= 1'b0;
                        o_SRAM_OE_N <= 1'b0;
                        o_SRAM_WE_N <= 1'b1;
                        o_SRAM_UB_N <= 1'b0;
                        o_SRAM_LB_N <= 1'b0;
`ifdef SRAM_ARB_RR_EN
                        last_rd     <= 1'b1;
`endif
                    end
                end
                WR: begin
                    if (cnt == CNT_W'(WR_CYCLES - 1)) begin
                        // WE rises while data stays driven for hold time.
                        state       <= WR_DONE;
                        cnt         <= '0;
                        o_SRAM_WE_N <= 1'b1;
                        o_wr_ack    <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WR_DONE: begin
                    state       <= IDLE;
                    dq_oe       <= 1'b0;
                    o_busy      <= 1'b0;
                    o_SRAM_CE_N <= 1'b1;
                    o_SRAM_UB_N <= 1'b1;
                    o_SRAM_LB_N <= 1'b1;
                end
                RD: begin
                    if (cnt == CNT_W'(RD_CYCLES - 1)) begin
                        state       <= RD_DONE;
                        cnt         <= '0;
                        o_rd_data   <= io_SRAM_DQ;
                        o_rd_ack    <= 1'b1;
                        o_SRAM_CE_N <= 1'b1;
                        o_SRAM_OE_N <= 1'b1;
                        o_SRAM_UB_N <= 1'b1;
                        o_SRAM_LB_N <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RD_DONE: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
                default: begin
                    state       <= IDLE;
                    cnt         <= '0;
                    dq_oe       <= 1'b0;
                    o_busy      <= 1'b0;
                    o_SRAM_CE_N <= 1'b1;
                    o_SRAM_OE_N <= 1'b1;
                    o_SRAM_WE_N <= 1'b1;
                    o_SRAM_UB_N <= 1'b1;
                    o_SRAM_LB_N <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed timing cases plus randomized traffic
// scored against a transaction-level memory model.
module tb_sram_arbiter;

    localparam int AW  = 20;
    localparam int DW  = 16;
    localparam int WRC = 2;
    localparam int RDC = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          wr_req, rd_req;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ack, rd_ack, busy;
    logic [DW-1:0] rd_data;
    logic [2:0]    dbg_state;
    logic [AW-1:0] sram_addr;
    logic          ce_n, oe_n, we_n, ub_n, lb_n;
    wire  [DW-1:0] sram_dq;

    sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WR_CYCLES(WRC), .RD_CYCLES(RDC)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_wr_req(wr_req), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .o_wr_ack(wr_ack),
        .i_rd_req(rd_req), .i_rd_addr(rd_addr), .o_rd_ack(rd_ack), .o_rd_data(rd_data),
        .o_busy(busy), .o_state(dbg_state),
        .o_SRAM_ADDR(sram_addr), .io_SRAM_DQ(sram_dq),
        .o_SRAM_CE_N(ce_n), .o_SRAM_OE_N(oe_n), .o_SRAM_WE_N(we_n),
        .o_SRAM_UB_N(ub_n), .o_SRAM_LB_N(lb_n)
    );

    // Released bus floats high so "not driven" is observable as all ones.
    pullup pu_dq (sram_dq);

    // ---------------- SRAM fixture and reference memory ----------------
    function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
        return a[15:0] ^ 16'h5A5A;
    endfunction

    logic [DW-1:0] sram [logic [AW-1:0]];
    logic [DW-1:0] sram_q;

    always @(negedge clk) begin
        if (!ce_n && !we_n) sram[sram_addr] = sram_dq;
        sram_q = sram.exists(sram_addr) ? sram[sram_addr] : init_word(sram_addr);
    end
    assign sram_dq = (!ce_n && !oe_n && we_n) ? sram_q : {DW{1'bz}};

    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [DW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // ---------------- driver tasks ----------------
    task automatic reset_dut(input int n);
        rst_n = 1'b0;
        repeat (n) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic write_single(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int ack_idx = 0, ack_cnt = 0, we_low = 0;
        bit dq_ok = 1, busy_ok = 1, addr_ok = 1;
        logic busy_after = 1'b1;
        wr_addr = a; wr_data = d; wr_req = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (!we_n) we_low++;
            if (k <= WRC + 1) begin
                if (sram_dq !== d) dq_ok = 0;
                if (!busy) busy_ok = 0;
                if (sram_addr !== a) addr_ok = 0;
            end
            if (k == WRC + 2) busy_after = busy;
            if (wr_ack) begin
                ack_cnt++;
                if (ack_idx == 0) ack_idx = k;
                wr_req = 1'b0;
                ref_mem[a] = d;
            end
        end
        wr_req = 1'b0;
        check("wr_ack_cycle", ack_idx, WRC + 1);
        check("wr_ack_count", ack_cnt, 1);
        check("wr_we_low_cycles", we_low, WRC);
        check("wr_dq_driven", {31'd0, dq_ok}, 1);
        check("wr_addr", {31'd0, addr_ok}, 1);
        check("wr_busy_during", {31'd0, busy_ok}, 1);
        check("wr_busy_after", {31'd0, busy_after}, 0);
    endtask

    task automatic read_single(input logic [AW-1:0] a);
        int ack_idx = 0, ack_cnt = 0, oe_low = 0;
        logic [DW-1:0] exp_d, at_ack;
        exp_d  = ref_rd(a);
        at_ack = '0;
        rd_addr = a; rd_req = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (!oe_n) oe_low++;
            if (rd_ack) begin
                ack_cnt++;
                if (ack_idx == 0) begin ack_idx = k; at_ack = rd_data; end
                rd_req = 1'b0;
            end
        end
        rd_req = 1'b0;
        check("rd_ack_cycle", ack_idx, RDC + 1);
        check("rd_ack_count", ack_cnt, 1);
        check("rd_oe_low_cycles", oe_low, RDC);
        check("rd_data_at_ack", at_ack, exp_d);
        check("rd_data_held", rd_data, exp_d);
    endtask

    // ---------------- test sequence ----------------
    logic got_w[8];
    logic exp_w[8];
    int   ack_cyc[8];

    initial begin
        rst_n = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
        wr_addr = '0; wr_data = '0; rd_addr = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_strobes", {27'd0, ce_n, oe_n, we_n, ub_n, lb_n}, 32'h1F);
        check("rst_dq_released", sram_dq, 16'hFFFF);
        check("rst_acks", {30'd0, wr_ack, rd_ack}, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_busy", busy, 0);
        check("rst_addr", sram_addr, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single write then read-back
        write_single(20'h00010, 16'hBEEF);
        read_single(20'h00010);

        // Reset during the second WR cycle aborts without ack
        begin
            int acks = 0;
            wr_addr = 20'h00123; wr_data = 16'h1111; wr_req = 1'b1;
            @(negedge clk);
            @(negedge clk);
            check("abort_in_wr", we_n, 0);
            rst_n = 1'b0; wr_req = 1'b0;
            @(negedge clk);
            check("abort_we_high", {30'd0, we_n, ce_n}, 3);
            check("abort_dq_released", sram_dq, 16'hFFFF);
            check("abort_busy", busy, 0);
            rst_n = 1'b1;
            if (wr_ack) acks++;
            repeat (4) begin
                @(negedge clk);
                if (wr_ack) acks++;
            end
            check("abort_no_ack", acks, 0);
            write_single(20'h00123, 16'h2222);
            read_single(20'h00123);
        end

        // Continuous contention for 8 accesses, starting from reset
        reset_dut(2);
        begin
            int n_ack = 0, n_rd = 0, cyc = 0;
            logic last_w = 1'b0;
            for (int i = 0; i < 8; i++) begin
`ifdef SRAM_ARB_RR_EN
                exp_w[i] = !last_w;
                last_w   = exp_w[i];
`else
                exp_w[i] = 1'b1;
`endif
            end
            wr_addr = 20'h00200; wr_data = $urandom_range(0, 16'hFFFF); wr_req = 1'b1;
            rd_addr = 20'h00010; rd_req = 1'b1;
            while (n_ack < 8 && cyc < 200) begin
                @(negedge clk);
                cyc++;
                if (wr_ack) begin
                    ref_mem[wr_addr] = wr_data;
                    got_w[n_ack] = 1'b1; ack_cyc[n_ack] = cyc; n_ack++;
                    wr_addr = wr_addr + 1'b1; wr_data = $urandom_range(0, 16'hFFFF);
                end
                if (rd_ack) begin
                    check("contend_rd_data", rd_data, ref_rd(rd_addr));
                    got_w[n_ack] = 1'b0; ack_cyc[n_ack] = cyc; n_ack++; n_rd++;
                end
            end
            wr_req = 1'b0; rd_req = 1'b0;
            check("contend_ack_total", n_ack, 8);
            for (int i = 0; i < n_ack; i++) begin
                check("contend_grant_order", got_w[i], exp_w[i]);
                if (i > 0) check("contend_period", ack_cyc[i] - ack_cyc[i-1], (exp_w[i] ? WRC : RDC) + 2);
            end
`ifdef SRAM_ARB_RR_EN
            check("contend_rd_acks", n_rd, 4);
`else
            check("contend_rd_acks", n_rd, 0);
`endif
            repeat (4) @(negedge clk);
        end

        // Back-to-back writes with req held across the ack, address wrap
        begin
            int n_ack = 0, gap = 0;
            int ack_k[2];
            ack_k[0] = 0; ack_k[1] = 0;
            wr_addr = 20'hFFFFF; wr_data = 16'hA5A5; wr_req = 1'b1;
            for (int k = 1; k <= 14; k++) begin
                @(negedge clk);
                if (n_ack == 1 && ce_n) gap++;
                if (wr_ack && n_ack < 2) begin
                    ref_mem[wr_addr] = wr_data;
                    ack_k[n_ack] = k; n_ack++;
                    if (n_ack == 1) begin wr_addr = 20'h00000; wr_data = 16'h5A5B; end
                    else wr_req = 1'b0;
                end
            end
            wr_req = 1'b0;
            check("b2b_ack_count", n_ack, 2);
            check("b2b_first_ack", ack_k[0], WRC + 1);
            check("b2b_spacing", ack_k[1] - ack_k[0], WRC + 2);
            check("b2b_idle_gap", gap, 1);
            read_single(20'hFFFFF);
            read_single(20'h00000);
        end

        // Randomized traffic against the reference memory
        begin
            int n_wr = 0, n_rd = 0;
            logic prev_oe = 1'b1;
            logic [31:0] expv;
            exp_q.delete();
            for (int cyc = 0; cyc < 900; cyc++) begin
                @(negedge clk);
                if (!oe_n && prev_oe) exp_q.push_back(ref_rd(rd_addr));
                prev_oe = oe_n;
                if (rd_ack) begin
                    expv = (exp_q.size() > 0) ? {16'd0, exp_q.pop_front()} : 32'hDEAD_0000;
                    check("rand_rd_data", rd_data, expv);
                    rd_req = 1'b0; n_rd++;
                end
                if (wr_ack) begin
                    ref_mem[wr_addr] = wr_data;
                    wr_req = 1'b0; n_wr++;
                end
                if (cyc < 800) begin
                    if (!wr_req && $urandom_range(0, 2) == 0) begin
                        wr_addr = AW'($urandom_range(0, 15));
                        wr_data = DW'($urandom_range(0, 16'hFFFF));
                        wr_req  = 1'b1;
                    end
                    if (!rd_req && $urandom_range(0, 1) == 0) begin
                        rd_addr = AW'($urandom_range(0, 15));
                        rd_req  = 1'b1;
                    end
                end
            end
            check("rand_drain_idle", {30'd0, wr_req, rd_req}, 0);
            check("rand_queue_empty", exp_q.size(), 0);
            check("rand_wr_seen", {31'd0, n_wr > 10}, 1);
            check("rand_rd_seen", {31'd0, n_rd > 5}, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
